// File: rtl/tl_pkg.sv
// ============================================================================
// Module      : tl_pkg
// Description : Shared light codes, phase encodings, requester IDs and the
//               round-robin pick helper for the intersection phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tl_pkg;

    localparam logic [1:0] L_R = 2'b00;
    localparam logic [1:0] L_G = 2'b01;
    localparam logic [1:0] L_Y = 2'b10;

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        ALLRED = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        WALK   = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        REQ_A = 2'd0,
        REQ_B = 2'd1,
        REQ_P = 2'd2
    } req_e;

    // One-hot pick of the first pending requester after 'last' (A->B->P->A);
    // all-zero when nothing is pending.
    function automatic logic [2:0] rr_pick(input req_e last, input logic [2:0] pend);
        logic [2:0] pick;
        int         idx;
        pick = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            idx = (int'(last) + i) % 3;
            if (pick == 3'b000 && pend[idx]) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_phase_timer.sv
// ============================================================================
// Module      : tl_phase_timer
// Description : Phase cycle counter; clears on state change, otherwise counts
//               up and saturates at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_phase_timer #(
    parameter int CW = 6
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt
);

    localparam logic [CW-1:0] C_MAX = '1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (cnt_q != C_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/tl_phase_sched.sv
// ============================================================================
// Module      : tl_phase_sched
// Description : Traffic-actuated phase scheduler for a two-road intersection
//               with pedestrian crossing; round-robin grant between A, B, P.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_phase_sched
    import tl_pkg::*;
#(
    parameter int T_GREEN_MIN = 8,
    parameter int T_GREEN_MAX = 32,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int T_WALK      = 10,
    parameter int CW          = 6
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_req_a,
    input  logic       i_req_b,
    input  logic       i_ped_req,
    input  logic       i_hold,
    output logic [1:0] o_light_a,
    output logic [1:0] o_light_b,
    output logic       o_walk,
    output logic       o_ped_pend,
    output logic [2:0] o_phase
);

    localparam logic [CW-1:0] C_GMIN = CW'(T_GREEN_MIN - 1);
    localparam logic [CW-1:0] C_GMAX = CW'(T_GREEN_MAX - 1);
    localparam logic [CW-1:0] C_YEL  = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] C_ARED = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] C_WALK = CW'(T_WALK - 1);

    phase_e        state_q, state_d;
    req_e          last_q, last_d;
    logic          ped_q, ped_d;
    logic [CW-1:0] cnt;
    logic          state_chg;
    logic [2:0]    grant;

    assign state_chg = (state_d != state_q);
    assign grant     = rr_pick(last_q, {ped_q, i_req_b, i_req_a});

    tl_phase_timer #(
        .CW (CW)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (state_chg),
        .o_cnt  (cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            A_GRN: begin
                if ((i_req_b || ped_q) && cnt >= C_GMIN &&
                    (!i_req_a || cnt >= C_GMAX) && !i_hold) begin
                    state_d = A_YEL;
                end
            end
            B_GRN: begin
                if ((i_req_a || ped_q) && cnt >= C_GMIN &&
                    (!i_req_b || cnt >= C_GMAX) && !i_hold) begin
                    state_d = B_YEL;
                end
            end
            A_YEL, B_YEL: begin
                if (cnt >= C_YEL) begin
                    state_d = ALLRED;
                end
            end
            WALK: begin
                if (cnt >= C_WALK && !i_hold) begin
                    state_d = ALLRED;
                end
            end
            ALLRED: begin
                // Road A is the rest phase when nobody is waiting.
                if (cnt >= C_ARED) begin
                    if (grant[1]) begin
                        state_d = B_GRN;
                    end else if (grant[2]) begin
                        state_d = WALK;
                    end else begin
                        state_d = A_GRN;
                    end
                end
            end
            default: state_d = A_GRN;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_chg) begin
            case (state_d)
                A_GRN:   last_d = REQ_A;
                B_GRN:   last_d = REQ_B;
                WALK:    last_d = REQ_P;
                default: last_d = last_q;
            endcase
        end
        // Clearing on WALK entry swallows a press in that same cycle.
        ped_d = ped_q | i_ped_req;
        if (state_chg && state_d == WALK) begin
            ped_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= A_GRN;
            last_q  <= REQ_A;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ped_q   <= ped_d;
        end
    end

    always_comb begin
        o_light_a = L_R;
        o_light_b = L_R;
        o_walk    = 1'b0;
        case (state_q)
            A_GRN:   o_light_a = L_G;
            A_YEL:   o_light_a = L_Y;
            B_GRN:   o_light_b = L_G;
            B_YEL:   o_light_b = L_Y;
            WALK:    o_walk    = 1'b1;
            default: o_walk    = 1'b0;
        endcase
    end

    assign o_ped_pend = ped_q;
    assign o_phase    = state_q;

endmodule

`default_nettype wire

// File: doc/tl_phase_sched.md
Name: tl_phase_sched

Overview:
Traffic-actuated phase scheduler for a two-road intersection with a pedestrian crossing. It shares the crossing between three requesters (road A, road B, pedestrian) using round-robin arbitration. Each phase is timed by an internal cycle counter. It drives the per-road 2-bit light codes and the walk signal, and replaces the untimed light sequencer as the intersection's top-level controller.

Parameters:
T_GREEN_MIN, 8, minimum green cycles before a phase may end
T_GREEN_MAX, 32, green cycles after which a continuing own-road request no longer extends the phase
T_YELLOW, 3, yellow cycles
T_ALLRED, 2, all-red clearance cycles
T_WALK, 10, pedestrian walk cycles
CW, 6, counter width; must satisfy 2^CW > every T_* value

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_req_a  in  1  road A vehicle sensor, level
i_req_b  in  1  road B vehicle sensor, level
i_ped_req  in  1  pedestrian button, pulse or level; latched internally
i_hold  in  1  manual hold: freezes the current green or walk phase
o_light_a  out  2  road A light: R=00, G=01, Y=10
o_light_b  out  2  road B light, same encoding
o_walk  out  1  pedestrian walk lamp
o_ped_pend  out  1  pedestrian request latched, not yet served
o_phase  out  3  current state encoding, for debug and status

Behaviour:
- Reset values: state=A_GRN, cnt=0, ped_pend=0, last_srv=A. Outputs at reset: light_a=G, light_b=R, walk=0, ped_pend=0.
- States and outputs (Moore, decoded from the state register only):
  - A_GRN: A=G, B=R
  - A_YEL: A=Y, B=R
  - ALLRED: A=R, B=R
  - B_GRN: A=R, B=G
  - B_YEL: A=R, B=Y
  - WALK: A=R, B=R, walk=1
- Counter:
  - cnt clears to 0 on every state change and increments otherwise.
  - cnt saturates at 2^CW-1; it never wraps.
  - A phase of length T occupies exactly T cycles: exit occurs on the edge where cnt==T-1.
- A_GRN exit requires all of:
  - other_pend = i_req_b | ped_pend
  - cnt>=T_GREEN_MIN-1
  - (!i_req_a | cnt>=T_GREEN_MAX-1)
  - !i_hold
- B_GRN exit is symmetric: other_pend = i_req_a | ped_pend, own request = i_req_b.
- With nothing pending, green rests indefinitely and cnt saturates.
- Fixed transitions:
  - A_GRN->A_YEL and B_GRN->B_YEL on the exit condition above.
  - A_YEL and B_YEL -> ALLRED after T_YELLOW cycles.
  - WALK -> ALLRED after T_WALK cycles. i_hold extends WALK while high.
- ALLRED exit after T_ALLRED cycles goes to the next grant:
  - Search the pending set {A:i_req_a, B:i_req_b, P:ped_pend} round-robin, starting at the requester after last_srv, in order A->B->P->A.
  - If none are pending, go to A_GRN (road A is the rest phase).
  - last_srv updates on entry to A_GRN, B_GRN or WALK.
- ped_pend:
  - Sets on i_ped_req==1.
  - Clears on the edge entering WALK.
  - A same-cycle i_ped_req on that edge is absorbed; clear wins.
  - i_ped_req during WALK sets ped_pend again, to be served in a later round.
- i_hold has no effect in YEL or ALLRED; clearance always completes.
- Reset mid-phase: asynchronously forces the reset values; no yellow or clearance is inserted.
- Safety invariant: never G or Y on both roads, and o_walk=1 only when both roads are R. The bench asserts this every cycle.

Decomposition:
- Shared package tl_pkg holds:
  - light codes L_R, L_G, L_Y
  - state encodings for the six states (3-bit)
  - requester IDs REQ_A, REQ_B, REQ_P
- One natural sub-module: tl_phase_timer. It is a CW-bit counter with synchronous clear-on-state-change and saturation, and outputs cnt.
- Next-state, arbiter and output decode stay in tl_phase_sched.

Test Plan:
- Reset release with i_req_b=1, i_req_a=0 -> A=G cycles 0-7, A=Y cycles 8-10, both R cycles 11-12, B=G from cycle 13.
- i_req_a=1 held and i_req_b=1 from reset -> A green extends to T_GREEN_MAX (cycles 0-31); A=Y at cycle 32.
- i_ped_req pulse in cycle 2 with no car requests -> o_ped_pend=1 from cycle 3; A=G ends at cycle 7; WALK for 10 cycles starting cycle 13; o_ped_pend=0 from cycle 13; after WALK, ALLRED then A_GRN.
- i_req_a, i_req_b, ped_pend all held pending -> grants rotate A->B->P->A; no requester is skipped.
- i_hold=1 during B_GRN with i_req_a=1 -> B stays G until i_hold drops; i_hold=1 asserted during B_YEL has no effect (3 cycles, then ALLRED).
- i_rstn low mid-WALK -> next cycle A=G, B=R, walk=0, ped_pend=0; safety assertion holds throughout all tests.
